i2s_tx: RTL and testbench

- Final audio output stage: serialises one stereo sample per frame onto the I2S pins routed to jb[1] (BCLK), jb[2] (SD) and jb[3] (LRCLK).
- Sits directly downstream of the mixer/reverb output.
- Accepts left/right samples over a valid/ready handshake into a one-deep holding buffer.
- Generates BCLK/LRCLK from the 100 MHz system clock.
- Standard Philips I2S format: MSB one BCLK after the LRCLK edge, 32-bit slots, 64 BCLK per frame.

---
 rtl/i2s_tx_pkg.sv | 28 ++
 rtl/i2s_tx_bclk_gen.sv | 37 +++
 rtl/i2s_tx.sv | 122 ++++++++++++
 tb/tb_i2s_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// Shared I2S framing constants and slot decode helpers for the audio output stage.
package i2s_tx_pkg;

    localparam int SAMPLE_WIDTH   = 24;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_BITS;
    localparam logic [5:0] LAST_BIT = 6'(I2S_FRAME_BITS - 1);

    typedef logic [5:0] bit_idx_t;

    typedef struct packed {
        logic       right;
        logic [4:0] pos;
    } slot_t;

    function automatic slot_t decode_slot(input bit_idx_t k);
        slot_t s;
        s.right = k[5];
        s.pos   = k[4:0];
        return s;
    endfunction

    // Slot position 0 is the Philips one-bit delay; data occupies 1..width.
    function automatic logic in_data(input logic [4:0] pos, input logic [4:0] width);
        return (pos != 5'd0) && (pos <= width);
    endfunction

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// Bit-clock divider: toggles BCLK every CLK_DIV_HALF clk cycles and flags the falling edge.
module i2s_tx_bclk_gen #(
    parameter int CLK_DIV_HALF = 16
) (
    input  logic clk_i,
    input  logic rstn_i,
    output logic bclk_o,
    output logic fall_tick_o
);

    localparam int DW = $clog2(CLK_DIV_HALF);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV_HALF - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    always_comb begin
        wrap      = (div_cnt_q == LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign fall_tick_o = wrap && bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-deep stereo holding buffer, 64-BCLK frames, MSB first.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int WIDTH        = SAMPLE_WIDTH,
    parameter int CLK_DIV_HALF = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             i2s_bclk,
    output logic             i2s_lrclk,
    output logic             i2s_sd,
    output logic             frame_start,
    output logic             underflow
);

    localparam logic [4:0] W5 = 5'(WIDTH);

    logic             fall_tick;
    logic             frame_load, xfer;
    slot_t            slot;

    bit_idx_t         bit_cnt_q, bit_cnt_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic             lrclk_q, lrclk_d, sd_q, sd_d;
    logic             s_ready_q, s_ready_d;
    logic             frame_start_q, frame_start_d, underflow_q, underflow_d;

    i2s_tx_bclk_gen #(.CLK_DIV_HALF(CLK_DIV_HALF)) u_bclk (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .bclk_o      (i2s_bclk),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        frame_load = fall_tick && (bit_cnt_q == LAST_BIT);
        xfer       = s_valid && s_ready_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        sd_d       = sd_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        slot       = decode_slot(bit_cnt_q + 6'd1);

        if (fall_tick) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrclk_d   = slot.right;
            sd_d      = 1'b0;
            if (frame_load) begin
                sh_l_d = buf_full_q ? buf_l_q : '0;
                sh_r_d = buf_full_q ? buf_r_q : '0;
            end else if (in_data(slot.pos, W5)) begin
                if (slot.right) begin
                    sd_d   = sh_r_q[WIDTH-1];
                    sh_r_d = sh_r_q << 1;
                end else begin
                    sd_d   = sh_l_q[WIDTH-1];
                    sh_l_d = sh_l_q << 1;
                end
            end
        end

        // The load consumes the old contents before a same-cycle transfer refills it.
        if (frame_load) buf_full_d = 1'b0;
        if (xfer) begin
            buf_full_d = 1'b1;
            buf_l_d    = s_left;
            buf_r_d    = s_right;
        end

        // A load that empties a full buffer reopens the handshake one cycle later.
        s_ready_d     = !buf_full_d && !(frame_load && buf_full_q);
        frame_start_d = frame_load;
        underflow_d   = frame_load && !buf_full_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt_q     <= LAST_BIT;
            buf_full_q    <= 1'b0;
            sh_l_q        <= '0;
            sh_r_q        <= '0;
            lrclk_q       <= 1'b0;
            sd_q          <= 1'b0;
            s_ready_q     <= 1'b1;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            buf_full_q    <= buf_full_d;
            sh_l_q        <= sh_l_d;
            sh_r_q        <= sh_r_d;
            lrclk_q       <= lrclk_d;
            sd_q          <= sd_d;
            s_ready_q     <= s_ready_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_l_q <= buf_l_d;
        buf_r_q <= buf_r_d;
    end

    assign s_ready     = s_ready_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_sd      = sd_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame timing, data layout, handshake, underflow and reset abort.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [23:0] s_left = '0, s_right = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, i2s_bclk, i2s_lrclk, i2s_sd, frame_start, underflow;

    int   n_vec = 0, n_err = 0;
    int   n_pat = 0;
    logic auto_drv = 1'b0, rdy_chk = 1'b0;
    logic bclk_prev = 1'b0, fs_prev = 1'b0;

    i2s_tx #(.WIDTH(24), .CLK_DIV_HALF(2)) dut (
        .clk(clk), .rstn(rstn), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
        .s_ready(s_ready), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sd(i2s_sd),
        .frame_start(frame_start), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frm(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    task automatic tick();
        logic xfer;
        xfer      = s_valid && s_ready && rstn;
        bclk_prev = i2s_bclk;
        fs_prev   = frame_start;
        @(posedge clk);
        #1;
        if (xfer) begin
            if (auto_drv) begin
                n_pat++;
                s_left  = 24'h100000 + 24'(n_pat);
                s_right = 24'hC00000 + 24'(n_pat);
            end else begin
                s_valid = 1'b0;
            end
        end
        if (rdy_chk && fs_prev)     chk("rdy_rise_after_fs", 64'(s_ready), 64'd1);
        if (rdy_chk && frame_start) chk("rdy_low_at_fs", 64'(s_ready), 64'd0);
    endtask

    task automatic do_reset(input int cycles);
        rstn     = 1'b0;
        s_valid  = 1'b0;
        auto_drv = 1'b0;
        rdy_chk  = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rstn = 1'b1;
    endtask

    task automatic wait_frame(output int cycles, output logic uf);
        cycles = 0;
        while (!frame_start && cycles < 300) begin
            tick();
            cycles++;
        end
        if (!frame_start) chk("frame_timeout", 64'(cycles), 64'd0);
        uf = underflow;
    endtask

    task automatic grab_frame(output logic [63:0] sd_bits, output logic [63:0] lr_bits);
        int guard;
        sd_bits = '0;
        lr_bits = '0;
        for (int b = 0; b < 64; b++) begin
            guard = 0;
            do begin
                tick();
                guard++;
            end while (!(i2s_bclk && !bclk_prev) && guard < 50);
            if (guard >= 50) chk("bclk_timeout", 64'(guard), 64'd0);
            sd_bits[63-b] = i2s_sd;
            lr_bits[63-b] = i2s_lrclk;
        end
    endtask

    initial begin
        int          cyc;
        logic        uf;
        logic [63:0] sd_b, lr_b;
        int          falls, guard;

        // Test 1: idle after reset -> underflow frame, zero data, LRCLK layout
        do_reset(5);
        chk("rst_bclk", 64'(i2s_bclk), 64'd0);
        chk("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        chk("rst_sd", 64'(i2s_sd), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd1);
        chk("rst_fs", 64'(frame_start), 64'd0);
        chk("rst_uf", 64'(underflow), 64'd0);
        wait_frame(cyc, uf);
        chk("t1_first_fall_cycle", 64'(cyc), 64'd4);
        chk("t1_uf", 64'(uf), 64'd1);
        grab_frame(sd_b, lr_b);
        chk("t1_sd", sd_b, 64'd0);
        chk("t1_lr", lr_b, {32'h0, 32'hFFFFFFFF});
        chk("t1_fs_pulse_done", 64'(frame_start), 64'd0);

        // Test 2: pair pushed before the first fall tick
        do_reset(3);
        s_left  = 24'hA5F00F;
        s_right = 24'h123456;
        s_valid = 1'b1;
        tick();
        chk("t2_ready_drop", 64'(s_ready), 64'd0);
        wait_frame(cyc, uf);
        chk("t2_uf", 64'(uf), 64'd0);
        grab_frame(sd_b, lr_b);
        chk("t2_sd", sd_b, frm(24'hA5F00F, 24'h123456));
        chk("t2_lr", lr_b, {32'h0, 32'hFFFFFFFF});

        // Test 3: continuous stream, 8 frames, one pair per frame
        do_reset(3);
        n_pat    = 0;
        s_left   = 24'h100000;
        s_right  = 24'hC00000;
        s_valid  = 1'b1;
        auto_drv = 1'b1;
        rdy_chk  = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_frame(cyc, uf);
            chk($sformatf("t3_uf_%0d", f), 64'(uf), 64'd0);
            grab_frame(sd_b, lr_b);
            chk($sformatf("t3_sd_%0d", f), sd_b,
                frm(24'h100000 + 24'(f), 24'hC00000 + 24'(f)));
        end
        rdy_chk = 1'b0;

        // Test 4: one missed frame produces a zero underflow frame
        do_reset(3);
        n_pat    = 0;
        s_left   = 24'h100000;
        s_right  = 24'hC00000;
        s_valid  = 1'b1;
        auto_drv = 1'b1;
        wait_frame(cyc, uf);
        grab_frame(sd_b, lr_b);
        chk("t4_f1", sd_b, frm(24'h100000, 24'hC00000));
        wait_frame(cyc, uf);
        s_valid = 1'b0;
        chk("t4_f2_uf", 64'(uf), 64'd0);
        grab_frame(sd_b, lr_b);
        chk("t4_f2", sd_b, frm(24'h100001, 24'hC00001));
        wait_frame(cyc, uf);
        chk("t4_f3_uf", 64'(uf), 64'd1);
        s_valid = 1'b1;
        grab_frame(sd_b, lr_b);
        chk("t4_f3", sd_b, 64'd0);
        wait_frame(cyc, uf);
        chk("t4_f4_uf", 64'(uf), 64'd0);
        grab_frame(sd_b, lr_b);
        chk("t4_f4", sd_b, frm(24'h100002, 24'hC00002));

        // Test 5: reset at bit 40 with a full buffer discards the pair
        do_reset(3);
        s_left  = 24'h111111;
        s_right = 24'h222222;
        s_valid = 1'b1;
        wait_frame(cyc, uf);
        chk("t5_f1_uf", 64'(uf), 64'd0);
        s_left  = 24'h333333;
        s_right = 24'h444444;
        s_valid = 1'b1;
        falls = 0;
        guard = 0;
        while (falls < 40 && guard < 400) begin
            tick();
            guard++;
            if (!i2s_bclk && bclk_prev) falls++;
        end
        chk("t5_fall_count", 64'(falls), 64'd40);
        chk("t5_lrclk_bit40", 64'(i2s_lrclk), 64'd1);
        chk("t5_buf_full", 64'(s_ready), 64'd0);
        rstn = 1'b0;
        tick();
        chk("t5_rst_bclk", 64'(i2s_bclk), 64'd0);
        chk("t5_rst_lrclk", 64'(i2s_lrclk), 64'd0);
        chk("t5_rst_sd", 64'(i2s_sd), 64'd0);
        chk("t5_rst_ready", 64'(s_ready), 64'd1);
        chk("t5_rst_fs_uf", {62'd0, frame_start, underflow}, 64'd0);
        rstn = 1'b1;
        wait_frame(cyc, uf);
        chk("t5_after_cycle", 64'(cyc), 64'd4);
        chk("t5_after_uf", 64'(uf), 64'd1);
        grab_frame(sd_b, lr_b);
        chk("t5_after_sd", sd_b, 64'd0);

        // Test 6: extreme values, no sign extension into padding
        do_reset(3);
        s_left  = 24'h800000;
        s_right = 24'h7FFFFF;
        s_valid = 1'b1;
        wait_frame(cyc, uf);
        chk("t6_uf", 64'(uf), 64'd0);
        grab_frame(sd_b, lr_b);
        chk("t6_sd", sd_b, {1'b0, 1'b1, 23'd0, 7'd0, 1'b0, 1'b0, {23{1'b1}}, 7'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
